// File: rtl/n_bit_serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell and a registered carry produce
// answer = a + b one bit per cycle, LSB first, over WIDTH RUN cycles plus DONE.
module n_bit_serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   answer
);

  // Handshake: start is sampled only while busy=0 (IDLE); a and b are captured
  // on that same edge. busy stays high through RUN and DONE, and starts seen
  // then are dropped, not queued. done pulses for one cycle when answer is
  // updated; answer holds its value until the next done.

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   answer_q, answer_d;
  logic             done_q, done_d;
  logic             s;
  logic [WIDTH:0]   sum_ext;

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    answer_d = answer_q;
    done_d   = 1'b0;
    s        = sa_q[0] ^ sb_q[0] ^ carry_q;
    sum_ext  = {s, sum_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          sum_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        carry_d = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);
        // Sum bits enter at the MSB so the first (LSB) bit lands at bit 0.
        sum_d   = sum_ext[WIDTH:1];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        answer_d = {carry_q, sum_q};
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      answer_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      answer_q <= answer_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign answer = answer_q;

endmodule

// File: tb/tb_n_bit_serial_adder.sv
// Bench for n_bit_serial_adder: table vectors, hand-built corner sequences and
// random operations on WIDTH=4 and WIDTH=8 instances against a plain a+b model.
module tb_n_bit_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4;
  logic [4:0] ans4;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8;
  logic [8:0] ans8;

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_q[$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[8];

  n_bit_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .answer(ans4)
  );

  n_bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .answer(ans8)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver helpers
  task automatic drive(input int w, input logic st, input logic [7:0] a, input logic [7:0] b);
    if (w == 4) begin
      start4 = st; a4 = a[3:0]; b4 = b[3:0];
    end else begin
      start8 = st; a8 = a; b8 = b;
    end
  endtask

  function automatic logic cur_done(input int w);
    return (w == 4) ? done4 : done8;
  endfunction

  function automatic logic cur_busy(input int w);
    return (w == 4) ? busy4 : busy8;
  endfunction

  function automatic logic [8:0] cur_ans(input int w);
    return (w == 4) ? {4'b0, ans4} : ans8;
  endfunction

  // One complete operation; the model result goes into exp_q at capture.
  task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b,
                        input bit scramble, output logic [8:0] ans);
    logic [7:0] mask;
    logic [8:0] prev;
    logic [8:0] exp;
    int  k;
    bit  seen;
    bit  unstable;
    bit  busy_low;
    mask = (w == 4) ? 8'h0f : 8'hff;
    @(negedge clk);
    drive(w, 1'b1, a, b);
    exp_q.push_back(9'(a & mask) + 9'(b & mask));
    prev = cur_ans(w);
    @(negedge clk);
    if (scramble) drive(w, 1'b0, 8'($urandom), 8'($urandom));
    else drive(w, 1'b0, a, b);
    check("busy_after_capture", 32'(cur_busy(w)), 32'd1);
    k = 0; seen = 0; unstable = 0; busy_low = 0;
    while (k < 20 && !seen) begin
      @(negedge clk);
      k++;
      if (scramble) drive(w, 1'b0, 8'($urandom), 8'($urandom));
      if (cur_done(w)) begin
        seen = 1;
      end else begin
        if (cur_ans(w) !== prev) unstable = 1;
        if (k <= w && !cur_busy(w)) busy_low = 1;
      end
    end
    check("done_latency", 32'(k), 32'(w + 1));
    check("answer_stable_in_run", 32'(unstable), 32'd0);
    check("busy_held_in_run", 32'(busy_low), 32'd0);
    ans = cur_ans(w);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1ff;
    check("answer_vs_model", 32'(ans), 32'(exp));
    check("busy_low_at_done", 32'(cur_busy(w)), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(cur_done(w)), 32'd0);
    check("answer_holds", 32'(cur_ans(w)), 32'(ans));
  endtask

  initial begin
    logic [8:0] ans;
    int         done_cnt;
    int         first_idx;
    int         second_idx;
    bit         saw_done;

    vecs[0] = '{a: 4'd7,  b: 4'd9,  exp: 5'd16};
    vecs[1] = '{a: 4'd15, b: 4'd15, exp: 5'd30};
    vecs[2] = '{a: 4'd0,  b: 4'd0,  exp: 5'd0};
    vecs[3] = '{a: 4'd3,  b: 4'd4,  exp: 5'd7};
    vecs[4] = '{a: 4'd1,  b: 4'd2,  exp: 5'd3};
    vecs[5] = '{a: 4'd12, b: 4'd5,  exp: 5'd17};
    vecs[6] = '{a: 4'd8,  b: 4'd8,  exp: 5'd16};
    vecs[7] = '{a: 4'd15, b: 4'd1,  exp: 5'd16};

    // reset state
    #12;
    check("reset_busy4", 32'(busy4), 32'd0);
    check("reset_done4", 32'(done4), 32'd0);
    check("reset_answer4", 32'(ans4), 32'd0);
    check("reset_answer8", 32'(ans8), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // table vectors
    for (int i = 0; i < 8; i++) begin
      run_op(4, 8'(vecs[i].a), 8'(vecs[i].b), 1'b0, ans);
      check("table_answer", 32'(ans), 32'(vecs[i].exp));
    end

    // start held high for 10 cycles: captures only at IDLE, at edges 1 and 7
    @(negedge clk);
    drive(4, 1'b1, 8'd3, 8'd4);
    done_cnt = 0; first_idx = -1; second_idx = -1;
    for (int idx = 1; idx <= 16; idx++) begin
      @(negedge clk);
      if (idx == 10) drive(4, 1'b0, 8'd3, 8'd4);
      if (done4) begin
        done_cnt++;
        if (first_idx < 0) first_idx = idx;
        else second_idx = idx;
        check("held_start_answer", 32'(ans4), 32'd7);
      end
      if (idx == 7) check("held_start_recapture_busy", 32'(busy4), 32'd1);
    end
    check("held_start_done_count", 32'(done_cnt), 32'd2);
    check("held_start_first_done", 32'(first_idx), 32'd6);
    check("held_start_second_done", 32'(second_idx), 32'd12);

    // reset two cycles after start abandons the operation
    @(negedge clk);
    drive(4, 1'b1, 8'd12, 8'd5);
    @(negedge clk);
    drive(4, 1'b0, 8'd12, 8'd5);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrun_reset_busy", 32'(busy4), 32'd0);
    check("midrun_reset_answer", 32'(ans4), 32'd0);
    check("midrun_reset_done", 32'(done4), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done4) saw_done = 1;
    end
    check("midrun_reset_no_done", 32'(saw_done), 32'd0);
    run_op(4, 8'd1, 8'd2, 1'b0, ans);
    check("after_reset_answer", 32'(ans), 32'd3);

    // round trip against subtractor output: (a-b) mod 16 plus b gives a back
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [3:0] diff;
        diff = 4'(a - b);
        run_op(4, 8'(diff), 8'(b), 1'b0, ans);
        check("round_trip", 32'(ans[3:0]), 32'(a));
      end
    end

    // random operations with operands scrambled during RUN
    for (int i = 0; i < 200; i++) begin
      run_op(4, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 1'b1, ans);
    end
    for (int i = 0; i < 200; i++) begin
      run_op(8, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1, ans);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
